// File: rtl/delay_window_accum.sv
// delay_window_accum
// Per-channel steering-delay window accumulator placed after the BRAM sample
// buffer. After an accepted start it drops the first `delay` valid samples,
// then sums the next WIN valid samples and publishes the total on sum_out
// with a one-cycle sum_valid strobe.
//
// Build option: define DELAY_ACCUM_SQUARE_EN to accumulate data_in*data_in
// (window energy) instead of data_in. The port list, state machine and timing
// are the same in both builds.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; delay is latched when start is accepted
// SKIP  | discarding leading valid samples until dly_r have been seen
// ACC   | adding valid samples until WIN have been summed
// DONE  | single guard cycle after the strobe, busy still high
module delay_window_accum #(
  parameter int DATA_W = 4,
  parameter int WIN    = 8,
  parameter int DLY_W  = 3,
  parameter int SUM_W  = 11
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [DLY_W-1:0]  delay,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SKIP = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int WIN_CW = $clog2(WIN + 1);
  localparam logic [WIN_CW-1:0] WIN_LAST = WIN_CW'(WIN - 1);

`ifdef DELAY_ACCUM_SQUARE_EN
  localparam int TERM_W = 2 * DATA_W;
`else
  localparam int TERM_W = DATA_W;
`endif

  // Wide enough to hold both the accumulator and the added term, so the
  // add is done without losing carries before the final SUM_W truncation.
  localparam int EXT_W = (SUM_W > TERM_W) ? SUM_W : TERM_W;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [DLY_W-1:0]  dly_r;
  logic [DLY_W-1:0]  skip_cnt;
  logic [WIN_CW-1:0] win_cnt;
  logic [SUM_W-1:0]  acc;
  logic [TERM_W-1:0] term;
  logic [EXT_W-1:0]  sum_wide;
  logic [SUM_W-1:0]  sum_next;
  logic              skip_last;
  logic              win_last;

`ifdef DELAY_ACCUM_SQUARE_EN
  assign term = TERM_W'(data_in) * TERM_W'(data_in);
`else
  assign term = data_in;
`endif

  // Accumulator plus the current term; truncates modulo 2^SUM_W if SUM_W is undersized.
  always_comb begin
    sum_wide = EXT_W'(acc) + EXT_W'(term);
    sum_next = sum_wide[SUM_W-1:0];
  end

  // dly_r is never zero while in SKIP, so dly_r-1 is the terminal count.
  assign skip_last = (skip_cnt == (dly_r - DLY_W'(1)));
  assign win_last  = (win_cnt == WIN_LAST);

  assign busy = (state != S_IDLE);

  // Next-state decode; data_valid low holds SKIP and ACC in place.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (delay != '0) ? S_SKIP : S_ACC;
        end
      end
      S_SKIP: begin
        if (data_valid && skip_last) begin
          state_next = S_ACC;
        end
      end
      S_ACC: begin
        if (data_valid && win_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters, accumulator and output registers; a sample arriving with the
  // accepted start is deliberately ignored because IDLE never looks at data.
  always_ff @(posedge clock) begin
    if (rst) begin
      dly_r     <= '0;
      skip_cnt  <= '0;
      win_cnt   <= '0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dly_r    <= delay;
            skip_cnt <= '0;
            win_cnt  <= '0;
            acc      <= '0;
          end
        end
        S_SKIP: begin
          if (data_valid) begin
            skip_cnt <= skip_cnt + DLY_W'(1);
          end
        end
        S_ACC: begin
          if (data_valid) begin
            if (win_last) begin
              sum_out   <= sum_next;
              sum_valid <= 1'b1;
              acc       <= '0;
              win_cnt   <= '0;
            end else begin
              acc     <= sum_next;
              win_cnt <= win_cnt + WIN_CW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_window_accum.sv
// Self-checking bench for delay_window_accum. Expected sums come from a
// reference function that applies the skip-then-sum rule to the list of
// valid samples; squared expectations follow DELAY_ACCUM_SQUARE_EN.
module tb_delay_window_accum;

  localparam int DATA_W = 4;
  localparam int WIN    = 8;
  localparam int DLY_W  = 3;
  localparam int SUM_W  = 11;

`ifdef DELAY_ACCUM_SQUARE_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic              clock;
  logic              rst;
  logic              start;
  logic [DLY_W-1:0]  delay;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic [SUM_W-1:0]  sum_out;
  logic              sum_valid;
  logic              busy;

  int n_checks;
  int n_fail;

  delay_window_accum #(
    .DATA_W(DATA_W), .WIN(WIN), .DLY_W(DLY_W), .SUM_W(SUM_W)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .delay     (delay),
    .data_in   (data_in),
    .data_valid(data_valid),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: drop the first dly valid samples, sum the next WIN.
  function automatic int model(input int dly, input int s[$]);
    int a;
    a = 0;
    for (int i = dly; i < dly + WIN && i < s.size(); i++) begin
      a += SQ ? s[i] * s[i] : s[i];
    end
    return a % (1 << SUM_W);
  endfunction

  task automatic arm(input int d);
    start      = 1'b1;
    delay      = DLY_W'(d);
    data_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Plays samples as valid cycles with gaps of gmin..gmax idle cycles after
  // each, plus a short idle tail, and records what the outputs did.
  task automatic feed(input int samples[$], input int gmin, input int gmax,
                      output int pulses, output int pulse_at, output int got_sum,
                      output int busy_at_pulse, output int busy_after,
                      output int gap_changes);
    int v[$];
    int d[$];
    int idx[$];
    int bh[$];
    int pc;
    int prev;
    int g;
    foreach (samples[i]) begin
      v.push_back(1); d.push_back(samples[i]); idx.push_back(i);
      g = $urandom_range(gmax, gmin);
      for (int j = 0; j < g; j++) begin
        v.push_back(0); d.push_back(int'($urandom_range(15, 0))); idx.push_back(-1);
      end
    end
    for (int j = 0; j < 3; j++) begin
      v.push_back(0); d.push_back(int'($urandom_range(15, 0))); idx.push_back(-1);
    end
    pulses = 0; pulse_at = -1; got_sum = -1; busy_at_pulse = -1; busy_after = -1;
    gap_changes = 0; pc = -1;
    prev = int'(sum_out);
    for (int k = 0; k < v.size(); k++) begin
      data_valid = v[k][0];
      data_in    = DATA_W'(d[k]);
      tick();
      bh.push_back(int'(busy));
      if (sum_valid) begin
        pulses++;
        pulse_at      = idx[k];
        got_sum       = int'(sum_out);
        busy_at_pulse = int'(busy);
        pc            = k;
      end
      if (v[k] == 0 && (sum_valid || int'(sum_out) != prev)) gap_changes++;
      prev = int'(sum_out);
    end
    data_valid = 1'b0;
    if (pc >= 0 && pc + 1 < bh.size()) busy_after = bh[pc + 1];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = '0; delay = '0;
    for (int c = 0; c < 7; c++) begin
      rst        = (c < 2);
      data_valid = c[0];
      data_in    = DATA_W'(c * 3);
      tick();
      n_checks++;
      if (sum_out !== '0 || sum_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: sum_out=%0d sum_valid=%b busy=%b expected 0/0/0",
                 c, sum_out, sum_valid, busy);
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_ramp();
    int q[$];
    int p, pa, gs, bp, ba, gc;
    for (int i = 0; i < 8; i++) q.push_back(i);
    arm(0);
    feed(q, 0, 0, p, pa, gs, bp, ba, gc);
    n_checks++;
    if (p !== 1 || pa !== 7) begin
      n_fail++;
      $display("FAIL ramp_pulse: pulses=%0d at sample %0d expected 1 at 7", p, pa);
    end
    n_checks++;
    if (gs !== (SQ ? 140 : 28)) begin
      n_fail++;
      $display("FAIL ramp_sum: got %0d expected %0d", gs, SQ ? 140 : 28);
    end
    n_checks++;
    if (bp !== 1 || ba !== 0) begin
      n_fail++;
      $display("FAIL ramp_busy: busy at pulse=%0d after=%0d expected 1/0", bp, ba);
    end
  endtask

  task automatic test_delay();
    int q[$];
    int p, pa, gs, bp, ba, gc;
    for (int i = 0; i <= 10; i++) q.push_back(i);
    arm(3);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL delay_busy_after_arm: got %b expected 1", busy);
    end
    feed(q, 0, 0, p, pa, gs, bp, ba, gc);
    n_checks++;
    if (p !== 1 || pa !== 10 || gs !== (SQ ? 380 : 52)) begin
      n_fail++;
      $display("FAIL delay3_sum: pulses=%0d at %0d sum=%0d expected 1 at 10 sum=%0d",
               p, pa, gs, SQ ? 380 : 52);
    end
  endtask

  task automatic test_gapped();
    int q[$];
    int p, pa, gs, bp, ba, gc;
    for (int i = 0; i < 8; i++) q.push_back(5);
    arm(0);
    feed(q, 2, 2, p, pa, gs, bp, ba, gc);
    n_checks++;
    if (p !== 1 || pa !== 7 || gs !== (SQ ? 200 : 40)) begin
      n_fail++;
      $display("FAIL gapped_sum: pulses=%0d at %0d sum=%0d expected 1 at 7 sum=%0d",
               p, pa, gs, SQ ? 200 : 40);
    end
    n_checks++;
    if (gc !== 0) begin
      n_fail++;
      $display("FAIL gapped_idle_change: %0d gap cycles changed output, expected 0", gc);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int pulses;
    int p, pa, gs, bp, ba, gc;
    pulses = 0;
    arm(0);
    for (int i = 0; i < 8; i++) begin
      data_in    = DATA_W'(i);
      data_valid = 1'b1;
      start      = (i == 4);
      tick();
      if (sum_valid) pulses++;
    end
    start      = 1'b1;
    data_valid = 1'b0;
    tick();
    start = 1'b0;
    if (sum_valid) pulses++;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_in_done: busy=%b expected 0", busy);
    end
    n_checks++;
    if (pulses !== 1 || sum_out !== SUM_W'(SQ ? 140 : 28)) begin
      n_fail++;
      $display("FAIL busy_ignored_start: pulses=%0d sum=%0d expected 1 and %0d",
               pulses, sum_out, SQ ? 140 : 28);
    end
    start = 1'b1; delay = '0; data_valid = 1'b1; data_in = DATA_W'(9);
    tick();
    start = 1'b0; data_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_busy: busy=%b expected 1", busy);
    end
    for (int i = 0; i < 8; i++) q.push_back(int'($urandom_range(15, 0)));
    feed(q, 0, 1, p, pa, gs, bp, ba, gc);
    n_checks++;
    if (p !== 1 || gs !== model(0, q)) begin
      n_fail++;
      $display("FAIL start_sample_not_used: pulses=%0d sum=%0d expected 1 and %0d",
               p, gs, model(0, q));
    end
  endtask

  task automatic test_reset_mid();
    int q[$];
    int p, pa, gs, bp, ba, gc;
    arm(0);
    for (int i = 0; i < 4; i++) begin
      data_in = DATA_W'(6); data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sum_out !== '0 || sum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b sum_out=%0d sum_valid=%b expected 0/0/0",
               busy, sum_out, sum_valid);
    end
    data_in = DATA_W'(6); data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sum_out !== '0 || sum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_stays_idle: busy=%b sum_out=%0d sum_valid=%b expected 0/0/0",
               busy, sum_out, sum_valid);
    end
    for (int i = 0; i < 8; i++) q.push_back(2);
    arm(0);
    feed(q, 0, 0, p, pa, gs, bp, ba, gc);
    n_checks++;
    if (p !== 1 || gs !== (SQ ? 32 : 16)) begin
      n_fail++;
      $display("FAIL reset_mid_new_window: pulses=%0d sum=%0d expected 1 and %0d",
               p, gs, SQ ? 32 : 16);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int q[$];
      int d;
      int p, pa, gs, bp, ba, gc;
      d = (it == 0) ? 7 : int'($urandom_range(7, 0));
      for (int i = 0; i < d + WIN; i++) q.push_back(int'($urandom_range(15, 0)));
      arm(d);
      feed(q, 0, 2, p, pa, gs, bp, ba, gc);
      n_checks++;
      if (p !== 1 || pa !== d + WIN - 1 || gs !== model(d, q) || gc !== 0) begin
        n_fail++;
        $display("FAIL random_%0d delay=%0d: pulses=%0d at %0d sum=%0d gapchg=%0d expected 1 at %0d sum=%0d gapchg=0",
                 it, d, p, pa, gs, gc, d + WIN - 1, model(d, q));
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    delay      = '0;
    data_in    = '0;
    data_valid = 1'b0;
    test_reset();
    test_ramp();
    test_delay();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
